// File: rtl/minterm_gate_unit.sv
// minterm_gate_unit: bit-serial evaluator of a run-time selected 2-input
// Boolean function (4-bit truth table) over WIDTH-bit operands, LSB first,
// with valid/ready handshakes on both sides.
// Optional feature macro: MINTERM_GATE_COUNT_EN adds a population count
// output `ones` tracking the number of 1 bits in the result.
module minterm_gate_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       tt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef MINTERM_GATE_COUNT_EN
    output logic [$clog2(WIDTH+1)-1:0] ones,
`endif
    output logic             busy
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef MINTERM_GATE_COUNT_EN
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         tt_q, tt_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
`ifdef MINTERM_GATE_COUNT_EN
    logic [CNT_W-1:0]   ones_q, ones_d;
`endif

    logic               a_bit;
    logic               b_bit;
    logic               cur_bit;

    // Select the operand bits at the current index and look up the result bit.
    always_comb begin
        a_bit = 1'b0;
        b_bit = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_bit = a_q[i];
                b_bit = b_q[i];
            end
        end
        cur_bit = tt_q[{a_bit, b_bit}];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        tt_d    = tt_q;
        s_d     = s_q;
        idx_d   = idx_q;
`ifdef MINTERM_GATE_COUNT_EN
        ones_d  = ones_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    tt_d    = tt;
                    s_d     = '0;
                    idx_d   = '0;
`ifdef MINTERM_GATE_COUNT_EN
                    ones_d  = '0;
`endif
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        s_d[i] = cur_bit;
                    end
                end
`ifdef MINTERM_GATE_COUNT_EN
                if (cur_bit) begin
                    ones_d = ones_q + CNT_W'(1);
                end
`endif
                // Index saturates at the last bit; no wrap-around.
                if (idx_q == IDX_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            tt_q    <= '0;
            s_q     <= '0;
            idx_q   <= '0;
`ifdef MINTERM_GATE_COUNT_EN
            ones_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tt_q    <= tt_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
`ifdef MINTERM_GATE_COUNT_EN
            ones_q  <= ones_d;
`endif
        end
    end

    // in_ready also drops immediately while reset is held.
    assign in_ready  = (state_q == ST_IDLE) && !reset;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign s         = s_q;
`ifdef MINTERM_GATE_COUNT_EN
    assign ones      = ones_q;
`endif

endmodule

// File: tb/tb_minterm_gate_unit.sv
// Directed self-checking bench for minterm_gate_unit (WIDTH=4 and WIDTH=1).
module tb_minterm_gate_unit;

    logic       clk;
    int         n_checks;
    int         n_err;

    // WIDTH=4 instance signals
    logic       rst4, iv4, ir4, ov4, ordy4, busy4;
    logic [3:0] a4, b4, tt4, s4;
`ifdef MINTERM_GATE_COUNT_EN
    logic [2:0] ones4;
`endif

    // WIDTH=1 instance signals
    logic       rst1, iv1, ir1, ov1, ordy1, busy1;
    logic [0:0] a1, b1, s1;
    logic [3:0] tt1;
`ifdef MINTERM_GATE_COUNT_EN
    logic [0:0] ones1;
`endif

    minterm_gate_unit #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(rst4), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .tt(tt4), .out_valid(ov4), .out_ready(ordy4),
        .s(s4),
`ifdef MINTERM_GATE_COUNT_EN
        .ones(ones4),
`endif
        .busy(busy4)
    );

    minterm_gate_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .tt(tt1), .out_valid(ov1), .out_ready(ordy1),
        .s(s1),
`ifdef MINTERM_GATE_COUNT_EN
        .ones(ones1),
`endif
        .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid on the WIDTH=4 unit; checks cycles since accept.
    task automatic wait_done4(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!ov4 && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_lat"}, n, exp_lat);
    endtask

    // One full operation on the WIDTH=4 unit with immediate handoff.
    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] tt, input logic [3:0] exp_s, input int exp_ones);
        check_eq({tag, "_rdy"}, ir4, 1);
        iv4 = 1'b1; a4 = a; b4 = b; tt4 = tt; ordy4 = 1'b0;
        tick();
        iv4 = 1'b0;
        check_eq({tag, "_busy"}, busy4, 1);
        wait_done4(tag, 4);
        check_eq({tag, "_s"}, s4, exp_s);
`ifdef MINTERM_GATE_COUNT_EN
        check_eq({tag, "_ones"}, ones4, exp_ones);
`else
        if (exp_ones < 0) $display("negative popcount in table for %s", tag);
`endif
        ordy4 = 1'b1;
        tick();
        ordy4 = 1'b0;
        check_eq({tag, "_ov_after"}, ov4, 0);
        check_eq({tag, "_rdy_after"}, ir4, 1);
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_err    = 0;
        rst4 = 1'b1; iv4 = 1'b0; ordy4 = 1'b0; a4 = '0; b4 = '0; tt4 = '0;
        rst1 = 1'b1; iv1 = 1'b0; ordy1 = 1'b0; a1 = '0; b1 = '0; tt1 = '0;

        // Reset held for two cycles
        tick();
        check_eq("rst_rdy4_c1", ir4, 0);
        tick();
        check_eq("rst_rdy4_c2", ir4, 0);
        check_eq("rst_rdy1_c2", ir1, 0);
        rst4 = 1'b0;
        rst1 = 1'b0;
        #1;
        check_eq("post_rst_rdy4", ir4, 1);
        check_eq("post_rst_ov4", ov4, 0);
        check_eq("post_rst_busy4", busy4, 0);
        check_eq("post_rst_s4", s4, 0);
        check_eq("post_rst_rdy1", ir1, 1);
`ifdef MINTERM_GATE_COUNT_EN
        check_eq("post_rst_ones4", ones4, 0);
`endif

        // a'.b and function sweep
        run4("anotb", 4'b0011, 4'b0101, 4'b0010, 4'b0100, 1);
        run4("and",   4'b1010, 4'b1100, 4'b1000, 4'b1000, 1);
        run4("nor",   4'b1010, 4'b1100, 4'b0001, 4'b0001, 1);
        run4("xor",   4'b1010, 4'b1100, 4'b0110, 4'b0110, 2);

        // Backpressure: result held 3 cycles, new request offered during DONE
        iv4 = 1'b1; a4 = 4'b1111; b4 = 4'b0000; tt4 = 4'b1100;
        tick();
        iv4 = 1'b0;
        wait_done4("bp", 4);
        iv4 = 1'b1; a4 = 4'b0000; tt4 = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_ov_hold", ov4, 1);
            check_eq("bp_s_hold", s4, 4'b1111);
            check_eq("bp_rdy_hold", ir4, 0);
        end
`ifdef MINTERM_GATE_COUNT_EN
        check_eq("bp_ones", ones4, 4);
`endif
        ordy4 = 1'b1;
        tick();
        iv4 = 1'b0;
        ordy4 = 1'b0;
        check_eq("bp_ov_after", ov4, 0);
        check_eq("bp_rdy_after", ir4, 1);
        check_eq("bp_no_accept", busy4, 0);

        // Inputs changed and in_valid toggled during EVAL are ignored
        iv4 = 1'b1; a4 = 4'b0011; b4 = 4'b0101; tt4 = 4'b0010;
        tick();
        iv4 = 1'b0;
        tick();
        iv4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; tt4 = 4'b1111;
        check_eq("ign_rdy", ir4, 0);
        tick();
        iv4 = 1'b0;
        while (!ov4 && n < 20) begin
            tick();
            n++;
        end
        check_eq("ign_done", ov4, 1);
        check_eq("ign_s", s4, 4'b0100);
        ordy4 = 1'b1;
        tick();
        ordy4 = 1'b0;
        check_eq("ign_no_second", busy4, 0);

        // Reset in the middle of EVAL after two bits
        iv4 = 1'b1; a4 = 4'b1111; b4 = 4'b0000; tt4 = 4'b1100;
        tick();
        iv4 = 1'b0;
        tick();
        tick();
        check_eq("mid_partial_s", s4, 4'b0011);
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy4, 0);
        check_eq("mid_rst_ov", ov4, 0);
        check_eq("mid_rst_s", s4, 0);
        check_eq("mid_rst_rdy", ir4, 1);
        run4("after_rst", 4'b0011, 4'b0101, 4'b0010, 4'b0100, 1);

        // WIDTH=1: abort in EVAL, then a full operation
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; tt1 = 4'b0100;
        tick();
        iv1 = 1'b0;
        check_eq("w1_busy", busy1, 1);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        #1;
        check_eq("w1_rst_busy", busy1, 0);
        check_eq("w1_rst_s", s1, 0);
        iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        n = 0;
        while (!ov1 && n < 20) begin
            tick();
            n++;
        end
        check_eq("w1_lat", n, 1);
        check_eq("w1_s", s1, 1);
`ifdef MINTERM_GATE_COUNT_EN
        check_eq("w1_ones", ones1, 1);
`endif
        ordy1 = 1'b1;
        tick();
        ordy1 = 1'b0;
        check_eq("w1_ov_after", ov1, 0);
        check_eq("w1_rdy_after", ir1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/minterm_gate_unit.md
# minterm_gate_unit

- Parametrised, sequential successor of the fixed two-input minterm gates: evaluates any 2-input Boolean function, selected at run time by a 4-bit truth table, across WIDTH-bit operand vectors.
- Works bit-serially, LSB first, one bit per clock, behind valid/ready handshakes on input and output.
- Sits between operand registers and any consumer of the result vector.
- With `tt = 4'b0010` it reproduces a'.b per bit.

## Interface
Parameters:
- WIDTH, 4, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and tt present.
- in_ready  output  1  unit can accept; high only in IDLE and while reset is low.
- a  input  WIDTH  operand A; supplies the MSB of the minterm index.
- b  input  WIDTH  operand B; supplies the LSB of the minterm index.
- tt  input  4  truth table; s[i] = tt[{a[i],b[i]}], i.e. tt[m] is the output for minterm m.
- out_valid  output  1  result complete, held until taken.
- out_ready  input  1  consumer takes the result.
- s  output  WIDTH  result register.
- busy  output  1  high in EVAL or DONE.

## Operation
- FSM states: IDLE, EVAL, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b, tt; clear s to 0; clear bit index idx to 0; go to EVAL.
- EVAL:
  - Each cycle: s[idx] <= tt_q[{a_q[idx],b_q[idx]}]; idx <= idx+1.
  - When idx == WIDTH-1 on that edge, go to DONE.
  - in_valid is ignored; in_ready=0.
- DONE:
  - out_valid=1; s stable.
  - On out_ready: go to IDLE.
  - No same-cycle bypass: in_ready stays 0 in DONE.
- idx width is max(1, $clog2(WIDTH)); idx never exceeds WIDTH-1, so there is no wrap-around.
- s shows partial results during EVAL. Consumers sample s only when out_valid=1.
- Changes on a, b, tt after acceptance have no effect.

## Timing
- Reset values: in_ready=0 while reset is high, then 1; out_valid=0; busy=0; s=0; idx=0.
  - If MINTERM_GATE_COUNT_EN is defined: ones=0.
- Reset asserted in any state (including mid-EVAL or DONE with out_ready low) aborts the operation. After that edge the unit is in IDLE and the partial result is discarded.
- Handshake latency:
  - Accept edge at cycle k.
  - out_valid rises after edge k+WIDTH (WIDTH=1: after edge k+1).
  - Handoff edge at cycle j (out_valid && out_ready): in_ready is 1 from cycle j+1, so the next accept is at edge j+1 at the earliest.
- Throughput with out_ready held high: one result every WIDTH+2 cycles.
- out_ready high while out_valid=0 has no effect.
- in_valid and out_ready high in the same DONE cycle: only the handoff occurs.

## Configuration
- Macro: MINTERM_GATE_COUNT_EN.
- Defined:
  - Adds output port ones, width $clog2(WIDTH+1), giving the population count of s.
  - ones is cleared on accept and incremented in the same EVAL cycle that a 1 is written into s.
  - ones equals the popcount of s whenever out_valid=1.
- Undefined: port ones and its counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold reset 2 cycles → in_ready=0 during reset; then in_ready=1, out_valid=0, busy=0, s=0.
- a'.b, WIDTH=4: a=4'b0011, b=4'b0101, tt=4'b0010 → out_valid 4 cycles after accept, s=4'b0100; with COUNT_EN, ones=1.
- Function sweep: a=4'b1010, b=4'b1100:
  - tt=4'b1000 (AND) → s=4'b1000.
  - tt=4'b0001 (NOR) → s=4'b0001.
  - tt=4'b0110 (XOR) → s=4'b0110.
- Backpressure: hold out_ready low 3 cycles after out_valid → s and out_valid stable, in_ready=0; raise out_ready → out_valid=0 next cycle, in_ready=1.
- Ignore during EVAL: toggle in_valid and change a, b, tt mid-EVAL → result matches the originally latched operands; no second accept.
- Reset mid-EVAL (after 2 bits) → next cycle IDLE, s=0, out_valid=0; a new operation then completes correctly. Repeat with WIDTH=1: a=1, b=0, tt=4'b0100 → s=1 after 1 cycle.
